// File: rtl/sha256_sigma_cfu_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_sigma_cfu_ctrl_if : CFU request/response bundle for the sigma unit
// Revision : 1.0
// ---------------------------------------------------------------------------
interface sha256_sigma_cfu_ctrl_if #(
  parameter int ID_W = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_func;
  logic [ID_W-1:0] req_id;
  logic [31:0]     req_data0;
  logic [31:0]     req_data1;
  logic            resp_valid;
  logic            resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [31:0]     resp_data;
  logic            resp_err;
  logic            busy;

  modport master (
    output req_valid, req_func, req_id, req_data0, req_data1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err, busy
  );

  modport slave (
    input  req_valid, req_func, req_id, req_data0, req_data1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/sha256_sigma_cfu_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_sigma_cfu_ctrl : credit-controlled CFU front end for SHA-256 sigma
// Option macro SHA256_SIGMA_PIPE_EN adds an input stage (latency 2 vs 1).
// Revision : 1.0
// ---------------------------------------------------------------------------
module sha256_sigma_cfu_ctrl #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 2
) (
  input  wire logic               clk,
  input  wire logic               rst,
  sha256_sigma_cfu_ctrl_if.slave  cfu
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] c_PTR_LAST  = PTR_W'(DEPTH - 1);

  function automatic logic [31:0] f_ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] f_sigma(input logic [1:0] sel, input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    case (sel)
      2'd0:    r = f_ror(x, 2)  ^ f_ror(x, 13) ^ f_ror(x, 22);
      2'd1:    r = f_ror(x, 6)  ^ f_ror(x, 11) ^ f_ror(x, 25);
      2'd2:    r = f_ror(x, 7)  ^ f_ror(x, 18) ^ (x >> 3);
      default: r = f_ror(x, 17) ^ f_ror(x, 19) ^ (x >> 10);
    endcase
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic                   w_acc;
  logic                   w_pop;
  logic                   w_wr;
  logic [2:0]             w_src_func;
  logic [ID_W-1:0]        w_src_id;
  logic [31:0]            w_src_data;
  logic                   w_wr_err;
  logic [31:0]            w_wr_data;
  logic [CNT_W-1:0]       w_outs_nxt;
  logic                   w_unused;

  logic [CNT_W-1:0]       r_outs;
  logic                   r_req_ready;
  logic                   r_busy;
  logic [CNT_W-1:0]       r_fcnt;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [31:0]            r_mem_data [DEPTH];
  logic [ID_W-1:0]        r_mem_id   [DEPTH];
  logic                   r_mem_err  [DEPTH];

  assign w_acc    = cfu.req_valid && r_req_ready;
  assign w_pop    = (r_fcnt != '0) && cfu.resp_ready;
  assign w_unused = ^cfu.req_data1;

`ifdef SHA256_SIGMA_PIPE_EN
  logic             r_stg_valid;
  logic [2:0]       r_stg_func;
  logic [ID_W-1:0]  r_stg_id;
  logic [31:0]      r_stg_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stg_valid <= 1'b0;
      r_stg_func  <= '0;
      r_stg_id    <= '0;
      r_stg_data  <= '0;
    end else begin
      r_stg_valid <= w_acc;
      if (w_acc) begin
        r_stg_func <= cfu.req_func;
        r_stg_id   <= cfu.req_id;
        r_stg_data <= cfu.req_data0;
      end
    end
  end

  assign w_wr       = r_stg_valid;
  assign w_src_func = r_stg_func;
  assign w_src_id   = r_stg_id;
  assign w_src_data = r_stg_data;
`else
  assign w_wr       = w_acc;
  assign w_src_func = cfu.req_func;
  assign w_src_id   = cfu.req_id;
  assign w_src_data = cfu.req_data0;
`endif

  // Illegal functions still occupy a slot so ordering is preserved.
  assign w_wr_err  = w_src_func[2];
  assign w_wr_data = w_wr_err ? 32'h0 : f_sigma(w_src_func[1:0], w_src_data);

  always_comb begin
    w_outs_nxt = r_outs;
    case ({w_acc, w_pop})
      2'b10:   w_outs_nxt = r_outs + CNT_W'(1);
      2'b01:   w_outs_nxt = r_outs - CNT_W'(1);
      default: w_outs_nxt = r_outs;
    endcase
  end

  // Ready and busy come from the next count so neither has an input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outs      <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_outs      <= w_outs_nxt;
      r_req_ready <= (w_outs_nxt < c_DEPTH_CNT);
      r_busy      <= (w_outs_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_id[i]   <= '0;
        r_mem_err[i]  <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
    end else begin
      if (w_wr) begin
        r_mem_data[r_wr_ptr] <= w_wr_data;
        r_mem_id[r_wr_ptr]   <= w_src_id;
        r_mem_err[r_wr_ptr]  <= w_wr_err;
        r_wr_ptr             <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      case ({w_wr, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
        2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  assign cfu.req_ready  = r_req_ready;
  assign cfu.busy       = r_busy;
  assign cfu.resp_valid = (r_fcnt != '0);
  assign cfu.resp_id    = r_mem_id[r_rd_ptr];
  assign cfu.resp_data  = r_mem_data[r_rd_ptr];
  assign cfu.resp_err   = r_mem_err[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_sha256_sigma_cfu_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sha256_sigma_cfu_ctrl : directed self-checking bench for the sigma CFU
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_sha256_sigma_cfu_ctrl;

  localparam int ID_W  = 4;
  localparam int DEPTH = 2;
`ifdef SHA256_SIGMA_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  sha256_sigma_cfu_ctrl_if #(.ID_W(ID_W)) bus ();

  sha256_sigma_cfu_ctrl #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .cfu (bus)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_pops = 0;
  int          cyc    = 0;
  logic [36:0] want_q [$];
  int          pop_cyc [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, want);
    end
  endtask

  function automatic logic [36:0] mk(input logic err, input logic [3:0] id, input logic [31:0] d);
    return {err, id, d};
  endfunction

  // Bitwise reference, deliberately unlike a shift-or rotate.
  function automatic logic [31:0] ref_ror(input logic [31:0] x, input int n);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[(i + n) % 32];
    return r;
  endfunction

  function automatic logic [31:0] ref_shr(input logic [31:0] x, input int n);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (i + n < 32) ? x[i + n] : 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] ref_sigma(input logic [2:0] f, input logic [31:0] x);
    case (f)
      3'd0:    return ref_ror(x, 2)  ^ ref_ror(x, 13) ^ ref_ror(x, 22);
      3'd1:    return ref_ror(x, 6)  ^ ref_ror(x, 11) ^ ref_ror(x, 25);
      3'd2:    return ref_ror(x, 7)  ^ ref_ror(x, 18) ^ ref_shr(x, 3);
      3'd3:    return ref_ror(x, 17) ^ ref_ror(x, 19) ^ ref_shr(x, 10);
      default: return 32'h0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pops are judged at the falling edge, before the rising edge that commits them.
  initial forever begin
    @(negedge clk);
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      n_pops++;
      pop_cyc.push_back(cyc);
      if (want_q.size() == 0) begin
        chk("spurious_resp", 64'd1, 64'd0);
      end else begin
        chk("resp", {bus.resp_err, bus.resp_id, bus.resp_data}, want_q[0]);
        void'(want_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [3:0] id, input logic [31:0] d,
                       input logic [36:0] want, input bit rnd);
    bit acc;
    acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_func  = f;
    bus.req_id    = id;
    bus.req_data0 = d;
    bus.req_data1 = ~d;
    for (int k = 0; k < 64 && !acc; k++) begin
      if (rnd) bus.resp_ready = 1'($urandom_range(0, 1));
      acc = bus.req_ready;
      step();
    end
    if (acc) want_q.push_back(want);
    else chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_data0 = '0;
    bus.req_func  = '0;
  endtask

  task automatic drain();
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 100 && want_q.size() != 0; k++) step();
    step();
    chk("drain_left", 64'(want_q.size()), 64'd0);
    chk("drain_valid", 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          base;
    logic [2:0]  f;
    logic [31:0] d;

    bus.req_valid  = 1'b0;
    bus.req_func   = '0;
    bus.req_id     = '0;
    bus.req_data0  = '0;
    bus.req_data1  = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    chk("rst_req_ready",  64'(bus.req_ready),  64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_id",    64'(bus.resp_id),    64'd0);
    chk("rst_resp_data",  64'(bus.resp_data),  64'd0);
    chk("rst_resp_err",   64'(bus.resp_err),   64'd0);
    chk("rst_busy",       64'(bus.busy),       64'd0);

    // First request and its latency.
    bus.resp_ready = 1'b1;
    issue(3'd0, 4'd3, 32'h0000_0001, mk(1'b0, 4'd3, 32'h4008_0400), 1'b0);
    idle();
    repeat (LAT - 1) step();
    chk("lat_valid", 64'(bus.resp_valid), 64'd1);
    chk("lat_data",  64'(bus.resp_data),  64'h4008_0400);
    chk("lat_id",    64'(bus.resp_id),    64'd3);
    chk("lat_err",   64'(bus.resp_err),   64'd0);
    drain();

    // Back-to-back stream.
    pop_cyc.delete();
    issue(3'd1, 4'd0, 32'h0000_0001, mk(1'b0, 4'd0, 32'h0420_0080), 1'b0);
    issue(3'd2, 4'd1, 32'h0000_0001, mk(1'b0, 4'd1, 32'h0200_4000), 1'b0);
    issue(3'd3, 4'd2, 32'h0000_0400, mk(1'b0, 4'd2, 32'h0280_0001), 1'b0);
    idle();
    drain();
    chk("b2b_count", 64'(pop_cyc.size()), 64'd3);
`ifndef SHA256_SIGMA_PIPE_EN
    if (pop_cyc.size() == 3) begin
      chk("b2b_gap0", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
      chk("b2b_gap1", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);
    end
`endif

    // Backpressure: credits run out after DEPTH accepts.
    bus.resp_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      issue(3'd2, 4'(k + 4), 32'h0000_0001, mk(1'b0, 4'(k + 4), 32'h0200_4000), 1'b0);
      chk("bp_ready", 64'(bus.req_ready), (k + 1 < DEPTH) ? 64'd1 : 64'd0);
    end
    idle();
    chk("bp_busy", 64'(bus.busy), 64'd1);
    repeat (LAT) step();
    chk("bp_valid", 64'(bus.resp_valid), 64'd1);
    chk("bp_hold",  64'(bus.req_ready),  64'd0);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    chk("bp_reopen", 64'(bus.req_ready), 64'd1);
    chk("bp_busy2",  64'(bus.busy),      64'd1);
    drain();

    // Illegal function ordered between two legal ones.
    issue(3'd0, 4'd6, 32'h0000_0001, mk(1'b0, 4'd6, 32'h4008_0400), 1'b0);
    issue(3'd5, 4'd7, 32'hFFFF_FFFF, mk(1'b1, 4'd7, 32'h0000_0000), 1'b0);
    issue(3'd3, 4'd8, 32'h0000_0400, mk(1'b0, 4'd8, 32'h0280_0001), 1'b0);
    idle();
    drain();

    // Reset while the FIFO is full.
    bus.resp_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      issue(3'd1, 4'(k + 10), 32'h0000_0001, mk(1'b0, 4'(k + 10), 32'h0420_0080), 1'b0);
    idle();
    repeat (LAT) step();
    chk("mid_full", 64'(bus.resp_valid), 64'd1);
    rst = 1'b1;
    want_q.delete();
    step();
    rst = 1'b0;
    chk("mid_valid", 64'(bus.resp_valid), 64'd0);
    chk("mid_ready", 64'(bus.req_ready),  64'd1);
    chk("mid_busy",  64'(bus.busy),       64'd0);
    chk("mid_data",  64'(bus.resp_data),  64'd0);
    base = n_pops;
    bus.resp_ready = 1'b1;
    issue(3'd1, 4'd9, 32'h0000_0001, mk(1'b0, 4'd9, 32'h0420_0080), 1'b0);
    idle();
    drain();
    chk("mid_only_own", 64'(n_pops - base), 64'd1);

    // Pointer wrap with random consumer stalls.
    base = n_pops;
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      f = 3'($urandom_range(0, 7));
      d = $urandom;
      issue(f, 4'(i), d, (f >= 3'd4) ? mk(1'b1, 4'(i), 32'h0) : mk(1'b0, 4'(i), ref_sigma(f, d)), 1'b1);
    end
    idle();
    drain();
    chk("wrap_count", 64'(n_pops - base), 64'(3 * DEPTH + 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
